// File: rtl/flag_stage.sv
// Flag stage: a 2-entry result/flag FIFO plus the architectural CCR, updated on push under a per-flag mask.
// Define FLAG_STAGE_COND_EVAL_EN to build the condition-code evaluator; otherwise cond_true is tied to 0.
module flag_stage #(
  parameter int         op_size = 4,
  parameter logic [3:0] c_mask  = 4'b1000,
  parameter logic [3:0] v_mask  = 4'b0100,
  parameter logic [3:0] n_mask  = 4'b0010,
  parameter logic [3:0] z_mask  = 4'b0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [op_size-1:0] in_r,
  input  logic [3:0]         in_ccr,
  input  logic [3:0]         in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [op_size-1:0] out_r,
  output logic [3:0]         out_ccr,
  output logic [3:0]         ccr,
  input  logic [3:0]         cond_sel,
  output logic               cond_true
);

  localparam int depth = 2;

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] ccr_q, ccr_d;
  logic       push, pop;

  logic [depth-1:0][op_size-1:0] r_word;
  logic [depth-1:0][3:0]         ccr_word;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage entries carry no reset: occupancy alone decides what is visible.
  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_entry
      logic [op_size-1:0] r_q, r_d;
      logic [3:0]         f_q, f_d;

      always_comb begin
        r_d = r_q;
        f_d = f_q;
        if (push && !rst && (wr_ptr_q == 1'(gi))) begin
          r_d = in_r;
          f_d = in_ccr;
        end
      end

      always_ff @(posedge clk) begin
        r_q <= r_d;
        f_q <= f_d;
      end

      assign r_word[gi]   = r_q;
      assign ccr_word[gi] = f_q;
    end
  endgenerate

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ccr_d    = ccr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      ccr_d    = (ccr_q & ~in_mask) | (in_ccr & in_mask);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ccr_q    <= 4'b0000;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ccr_q    <= ccr_d;
    end
  end

  assign out_r   = out_valid ? r_word[rd_ptr_q]   : '0;
  assign out_ccr = out_valid ? ccr_word[rd_ptr_q] : 4'b0000;
  assign ccr     = ccr_q;

`ifdef FLAG_STAGE_COND_EVAL_EN
  logic c_flag, v_flag, n_flag, z_flag;
  logic cond_eval;

  assign c_flag = |(ccr_q & c_mask);
  assign v_flag = |(ccr_q & v_mask);
  assign n_flag = |(ccr_q & n_mask);
  assign z_flag = |(ccr_q & z_mask);

  always_comb begin
    cond_eval = 1'b0;
    case (cond_sel)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = 1'b0;
      4'd2:    cond_eval = z_flag;
      4'd3:    cond_eval = ~z_flag;
      4'd4:    cond_eval = c_flag;
      4'd5:    cond_eval = ~c_flag;
      4'd6:    cond_eval = n_flag;
      4'd7:    cond_eval = ~n_flag;
      4'd8:    cond_eval = v_flag;
      4'd9:    cond_eval = ~v_flag;
      4'd10:   cond_eval = ~(n_flag ^ v_flag);
      4'd11:   cond_eval = n_flag ^ v_flag;
      4'd12:   cond_eval = ~z_flag & ~(n_flag ^ v_flag);
      4'd13:   cond_eval = z_flag | (n_flag ^ v_flag);
      4'd14:   cond_eval = ~c_flag & ~z_flag;
      4'd15:   cond_eval = c_flag | z_flag;
      default: cond_eval = 1'b0;
    endcase
  end

  assign cond_true = cond_eval;
`else
  logic unused_cond_sel;
  assign unused_cond_sel = ^cond_sel;
  assign cond_true       = 1'b0;
`endif

endmodule

// File: tb/tb_flag_stage.sv
// Randomized bench for flag_stage: a queue-based reference model of the FIFO and CCR checked every cycle.
module tb_flag_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_r;
  logic [3:0] in_ccr;
  logic [3:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_r;
  logic [3:0] out_ccr;
  logic [3:0] ccr;
  logic [3:0] cond_sel;
  logic       cond_true;

  int errors = 0;
  int checks = 0;

  logic [3:0] q_r[$];
  logic [3:0] q_ccr[$];
  logic [3:0] m_ccr;
  bit         m_known = 1'b0;

  flag_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_ccr    (in_ccr),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_ccr   (out_ccr),
    .ccr       (ccr),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Conditions come in pairs: odd selectors are the negation of the even one below them.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] sel);
    logic c, v, n, z, base;
    c = f[3]; v = f[2]; n = f[1]; z = f[0];
    case (sel >> 1)
      0:       base = 1'b1;
      1:       base = z;
      2:       base = c;
      3:       base = n;
      4:       base = v;
      5:       base = (n == v);
      6:       base = !z && (n == v);
      default: base = !c && !z;
    endcase
`ifdef FLAG_STAGE_COND_EVAL_EN
    return base ^ sel[0];
`else
    return 1'b0 & base;
`endif
  endfunction

  task automatic step(input bit r, input bit v, input logic [3:0] dr, input logic [3:0] dc,
                      input logic [3:0] dm, input bit ordy, input logic [3:0] sel);
    bit do_push, do_pop;
    @(negedge clk);
    rst = r; in_valid = v; in_r = dr; in_ccr = dc; in_mask = dm;
    out_ready = ordy; cond_sel = sel;
    #1;
    if (m_known) begin
      check_eq("in_ready",  in_ready,  q_r.size() < 2);
      check_eq("out_valid", out_valid, q_r.size() > 0);
      check_eq("out_r",     out_r,     (q_r.size() > 0) ? q_r[0] : 4'd0);
      check_eq("out_ccr",   out_ccr,   (q_ccr.size() > 0) ? q_ccr[0] : 4'd0);
      check_eq("ccr",       ccr,       m_ccr);
      check_eq("cond_true", cond_true, cond_ref(m_ccr, sel));
    end
    @(posedge clk);
    if (r) begin
      q_r.delete();
      q_ccr.delete();
      m_ccr   = 4'b0000;
      m_known = 1'b1;
    end else if (m_known) begin
      do_push = v && (q_r.size() < 2);
      do_pop  = ordy && (q_r.size() > 0);
      if (do_pop) begin
        void'(q_r.pop_front());
        void'(q_ccr.pop_front());
      end
      if (do_push) begin
        q_r.push_back(dr);
        q_ccr.push_back(dc);
        m_ccr = (m_ccr & ~dm) | (dc & dm);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_ccr = '0; in_mask = '0;
    out_ready = 1'b0; cond_sel = '0;

    // Reset with a coincident push attempt, then a single push of 0110.
    step(1, 1, 4'h9, 4'hF, 4'hF, 0, 0);
    step(0, 1, 4'b0110, 4'b0000, 4'b1111, 0, 2);
    #1;
    check_eq("r031_out_valid", out_valid, 1);
    check_eq("r031_out_r", out_r, 4'b0110);
    check_eq("r031_ccr", ccr, 4'b0000);
    check_eq("r031_cond_eq", cond_true, 0);

    // Set ccr to 1010, then push with only Z enabled.
    step(0, 1, 4'h0, 4'b1010, 4'b1111, 1, 0);
    step(0, 1, 4'b1000, 4'b0001, 4'b0001, 1, 2);
    #1;
    check_eq("r032_ccr", ccr, 4'b1011);
    cond_sel = 4'd2;  #1;
`ifdef FLAG_STAGE_COND_EVAL_EN
    check_eq("r032_eq", cond_true, 1);
    cond_sel = 4'd15; #1;
    check_eq("r032_ls", cond_true, 1);
    cond_sel = 4'd14; #1;
    check_eq("r032_hi", cond_true, 0);
`else
    check_eq("r036_sel2", cond_true, 0);
    cond_sel = 4'd0;  #1;
    check_eq("r036_sel0", cond_true, 0);
`endif

    // Fill without draining; third push must be refused.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1, 4'b0001, 4'hF, 0, 3);
    step(0, 1, 4'd2, 4'b0010, 4'hF, 0, 3);
    step(0, 1, 4'd3, 4'b0100, 4'hF, 0, 3);
    #1;
    check_eq("r033_in_ready", in_ready, 0);
    check_eq("r033_ccr", ccr, 4'b0010);
    check_eq("r033_head", out_r, 4'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_eq("r033_second", out_r, 4'd2);

    // Count 1: push and pop on the same edge.
    step(0, 1, 4'd7, 4'b1000, 4'b1000, 1, 4);
    #1;
    check_eq("r034_out_r", out_r, 4'd7);
    check_eq("r034_in_ready", in_ready, 1);
    check_eq("r034_out_valid", out_valid, 1);

    // Full, then reset with in_valid high.
    step(0, 1, 4'd8, 4'b0110, 4'hF, 0, 0);
    step(1, 1, 4'd9, 4'b1111, 4'hF, 0, 0);
    #1;
    check_eq("r035_out_valid", out_valid, 0);
    check_eq("r035_in_ready", in_ready, 1);
    check_eq("r035_ccr", ccr, 4'b0000);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 3), $urandom_range(0, 1),
           4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 99) < 55), 4'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_stage.md
FLAG_STAGE -- requirements
Module: flag_stage

Interface
REQ-001 Parameter: op_size, default 4, result width in bits.
REQ-002 Parameter: c_mask/v_mask/n_mask/z_mask, defaults 'b1000/'b0100/'b0010/'b0001, flag bit positions within CCR (CVNZ order).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream shift/ALU stage offers {in_r, in_ccr, in_mask}.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_r  input  op_size  result R from upstream stage.
REQ-008 in_ccr  input  4  CVNZ flags produced with in_r.
REQ-009 in_mask  input  4  per-flag update enable (CVNZ order).
REQ-010 out_valid  output  1  head entry available downstream.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_r  output  op_size  head entry result.
REQ-013 out_ccr  output  4  head entry flags as produced upstream (unmasked).
REQ-014 ccr  output  4  architectural condition code register.
REQ-015 cond_sel  input  4  condition selector.
REQ-016 cond_true  output  1  selected condition evaluated against ccr.

Function
REQ-017 Push = in_valid & in_ready at a rising edge; pop = out_valid & out_ready at a rising edge.
REQ-018 The stage SHALL buffer entries {in_r, in_ccr} in a 2-entry FIFO with wrap-around read/write pointers and a 0..2 occupancy count.
REQ-019 in_ready SHALL be 1 iff count<2, independent of out_ready (no pass-through when full).
REQ-020 out_valid SHALL be 1 iff count>0; out_r/out_ccr SHALL show the head entry when valid and 0 when empty.
REQ-021 Latency: an entry pushed at edge k SHALL appear on out_valid/out_r/out_ccr after edge k (earliest pop at edge k+1), entries leave in push order.
REQ-022 Simultaneous push and pop with count 1 SHALL leave count 1, head = new entry; with count 2 only pop occurs (in_ready=0).
REQ-023 Pop with count 0 and push with count 2 SHALL be impossible by construction; pointers and count SHALL never change on them.
REQ-024 On push, ccr SHALL become (ccr & ~in_mask) | (in_ccr & in_mask); flags with mask bit 0 hold.
REQ-025 ccr SHALL change only on push; pop SHALL not affect ccr.
REQ-026 cond_true SHALL be combinational from ccr and cond_sel: 0 always, 1 never, 2 EQ Z, 3 NE !Z, 4 CS C, 5 CC !C, 6 MI N, 7 PL !N, 8 VS V, 9 VC !V, 10 GE N==V, 11 LT N^V, 12 GT !Z&(N==V), 13 LE Z|(N^V), 14 HI !C&!Z, 15 LS C|Z.
REQ-027 A push at edge k SHALL affect cond_true from edge k onward (same cycle ccr updates).

Reset
REQ-028 rst high at a rising edge SHALL set count=0, pointers=0, ccr=4'b0000 regardless of in_valid/out_ready; in_ready=1, out_valid=0, out_r=0, out_ccr=0 after that edge.
REQ-029 Reset mid-operation SHALL discard buffered entries; a push coincident with rst SHALL be dropped.

Configuration
REQ-030 Macro FLAG_STAGE_COND_EVAL_EN: defined -> cond_true per REQ-026; undefined -> cond_true tied to 0, cond_sel ignored, no evaluator logic synthesized; FIFO and ccr behaviour identical in both builds.

Verification
REQ-031 Reset, then push in_r=4'b0110, in_ccr=4'b0000, in_mask=4'b1111 -> next cycle out_valid=1, out_r=0110, ccr=0000, cond_sel=2 gives cond_true=0.
REQ-032 Push 4'b1000/ccr 4'b0001 mask 4'b0001 onto ccr=4'b1010 -> ccr=1011; cond_sel=2 (EQ)=1, cond_sel=15 (LS)=1, cond_sel=14 (HI)=0.
REQ-033 out_ready=0, push A=1, B=2, attempt C=3 -> in_ready=0 after second push, C not accepted, ccr updated by A and B only; then pops yield 1 then 2.
REQ-034 count=1, push and pop same edge -> count stays 1, out_r=new value, in_ready stays 1.
REQ-035 count=2, assert rst one cycle with in_valid=1 -> out_valid=0, in_ready=1, ccr=0000, no entry retained.
REQ-036 Build without FLAG_STAGE_COND_EVAL_EN, ccr=4'b0001, cond_sel=0 and 2 -> cond_true=0 both.
